// File: rtl/baud_pkg.sv
// Shared constants for the programmable baud-tick generator.
// Holds the default-divisor helper, minimum divisor and oversample default.
package baud_pkg;

  localparam int MIN_DIV    = 2;
  localparam int OS_DEFAULT = 16;

  function automatic int default_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator; its carry stretches the next os period.
// Only instantiated when BAUD_GEN_FRAC_EN is defined.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int FRAC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  step,
  input  logic [FRAC_WIDTH-1:0] frac,
  output logic                  carry
);

  logic [FRAC_WIDTH-1:0] acc;
  logic                  carry_q;
  logic [FRAC_WIDTH:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = carry_q;

  // carry_q belongs to the period that starts at this step
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (step) begin
      {carry_q, acc} <= sum;
    end
  end

endmodule

// File: rtl/baud_gen_prog.sv
// Runtime-programmable oversample/bit tick generator for UART TX/RX.
// Define BAUD_GEN_FRAC_EN to enable the fractional divisor.
module baud_gen_prog
  import baud_pkg::*;
#(
  parameter int CLOCK_FREQ   = 100000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = OS_DEFAULT,
  parameter int DIV_WIDTH    = 16,
  parameter int FRAC_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_load,
  input  logic                  sync_clr,
  output logic                  os_tick,
  output logic                  bit_tick,
  output logic                  div_err
);

  localparam int CW = DIV_WIDTH + 1;
  localparam int IW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV =
    DIV_WIDTH'(default_div(CLOCK_FREQ, DEFAULT_BAUD, OVERSAMPLE));
  localparam logic [IW-1:0] IDX_LAST = IW'(OVERSAMPLE - 1);

  logic [DIV_WIDTH-1:0] div_reg, div_nxt;
  logic [DIV_WIDTH-1:0] pend_div, pend_div_nxt;
  logic                 pend_vld, pend_vld_nxt;
  logic [CW-1:0]        os_cnt;
  logic [CW-1:0]        p_last;
  logic [IW-1:0]        os_idx;
  logic                 carry;
  logic                 load_ok;
  logic                 load_bad;
  logic                 at_end;
  logic                 adopt;

  assign load_ok  = div_load && (div_int >= DIV_WIDTH'(MIN_DIV));
  assign load_bad = div_load && !load_ok;
  assign p_last   = {1'b0, div_reg} + CW'(carry) - CW'(1);
  assign at_end   = en && !sync_clr && (os_cnt == p_last);
  assign adopt    = !en || sync_clr || at_end;

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_WIDTH-1:0] frac_reg, frac_nxt;
  logic [FRAC_WIDTH-1:0] pend_frac, pend_frac_nxt;

  baud_frac_acc #(
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_frac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!en || sync_clr),
    .step  (at_end),
    .frac  (frac_reg),
    .carry (carry)
  );
`else
  logic unused_frac;
  assign unused_frac = ^div_frac;
  assign carry       = 1'b0;
`endif

  // a staged divisor is adopted only where a new period begins
  always_comb begin
    div_nxt      = div_reg;
    pend_div_nxt = pend_div;
    pend_vld_nxt = pend_vld;
`ifdef BAUD_GEN_FRAC_EN
    frac_nxt      = frac_reg;
    pend_frac_nxt = pend_frac;
`endif
    if (load_ok) begin
      pend_div_nxt = div_int;
      pend_vld_nxt = 1'b1;
`ifdef BAUD_GEN_FRAC_EN
      pend_frac_nxt = div_frac;
`endif
    end
    if (adopt && pend_vld_nxt) begin
      div_nxt      = pend_div_nxt;
      pend_vld_nxt = 1'b0;
`ifdef BAUD_GEN_FRAC_EN
      frac_nxt = pend_frac_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_reg  <= DEFAULT_DIV;
      pend_div <= DEFAULT_DIV;
      pend_vld <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_reg  <= div_nxt;
      pend_div <= pend_div_nxt;
      pend_vld <= pend_vld_nxt;
      if (load_ok) begin
        div_err <= 1'b0;
      end else if (load_bad) begin
        div_err <= 1'b1;
      end
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frac_reg  <= '0;
      pend_frac <= '0;
    end else begin
      frac_reg  <= frac_nxt;
      pend_frac <= pend_frac_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      os_cnt   <= '0;
      os_idx   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      if (!en || sync_clr) begin
        os_cnt <= '0;
        os_idx <= '0;
      end else if (at_end) begin
        os_cnt  <= '0;
        os_tick <= 1'b1;
        if (os_idx == IDX_LAST) begin
          os_idx   <= '0;
          bit_tick <= 1'b1;
        end else begin
          os_idx <= os_idx + IW'(1);
        end
      end else begin
        os_cnt <= os_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_prog.sv
// Directed bench for baud_gen_prog (default div 40, oversample 4).
// Expected values are hand-computed cycle counts.
module tb_baud_gen_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        sync_clr;
  logic        os_tick;
  logic        bit_tick;
  logic        div_err;

  int tests = 0;
  int fails = 0;
  int stray = 0;
  int n;

  localparam int LIMIT = 2000;

  baud_gen_prog #(
    .CLOCK_FREQ   (1600),
    .DEFAULT_BAUD (10),
    .OVERSAMPLE   (4),
    .DIV_WIDTH    (16),
    .FRAC_WIDTH   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .sync_clr (sync_clr),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bit_tick && !os_tick) stray++;
  endtask

  task automatic wait_os(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!os_tick && cnt < LIMIT);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    sync_clr = 1'b0;
    div_int  = '0;
    div_frac = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic load(input int d, input int f);
    div_int  = 16'(d);
    div_frac = 4'(f);
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    en       = 1'b1;
    div_load = 1'b0;
    sync_clr = 1'b0;
    div_int  = '0;
    div_frac = '0;
    repeat (3) tick();
    tests++;
    if (os_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_os_tick got %b want 0", os_tick);
    end
    tests++;
    if (bit_tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_bit_tick got %b want 0", bit_tick);
    end
    tests++;
    if (div_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_div_err got %b want 0", div_err);
    end
  endtask

  task automatic test_default();
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_os(n);
      tests++;
      if (n !== 40) begin
        fails++;
        $display("FAIL default_period[%0d] got %0d want 40", i, n);
      end
      tests++;
      if (bit_tick !== ((i % 4) == 3)) begin
        fails++;
        $display("FAIL default_bit[%0d] got %b want %b", i, bit_tick,
                 (i % 4) == 3);
      end
    end
  endtask

  task automatic test_load();
    repeat (10) tick();
    load(5, 0);
    wait_os(n);
    tests++;
    if (n !== 29) begin
      fails++;
      $display("FAIL load_old_period got %0d want 29", n);
    end
    for (int i = 0; i < 3; i++) begin
      wait_os(n);
      tests++;
      if (n !== 5) begin
        fails++;
        $display("FAIL load_new_period[%0d] got %0d want 5", i, n);
      end
    end
    tests++;
    if (div_err !== 1'b0) begin
      fails++;
      $display("FAIL load_div_err got %b want 0", div_err);
    end
  endtask

  task automatic test_div_err();
    do_reset();
    wait_os(n);
    load(1, 0);
    wait_os(n);
    tests++;
    if (n !== 39) begin
      fails++;
      $display("FAIL err_period got %0d want 39", n);
    end
    wait_os(n);
    tests++;
    if (n !== 40) begin
      fails++;
      $display("FAIL err_period2 got %0d want 40", n);
    end
    tests++;
    if (div_err !== 1'b1) begin
      fails++;
      $display("FAIL err_set got %b want 1", div_err);
    end
    load(8, 0);
    tests++;
    if (div_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear got %b want 0", div_err);
    end
    wait_os(n);
    tests++;
    if (n !== 39) begin
      fails++;
      $display("FAIL err_tail got %0d want 39", n);
    end
    wait_os(n);
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL err_new_period got %0d want 8", n);
    end
  endtask

  task automatic test_frac();
    int exp_p [5];
`ifdef BAUD_GEN_FRAC_EN
    exp_p = '{5, 5, 6, 5, 6};
`else
    exp_p = '{5, 5, 5, 5, 5};
`endif
    load(5, 8);
    wait_os(n);
    tests++;
    if (n !== 7) begin
      fails++;
      $display("FAIL frac_tail got %0d want 7", n);
    end
    for (int i = 0; i < 5; i++) begin
      wait_os(n);
      tests++;
      if (n !== exp_p[i]) begin
        fails++;
        $display("FAIL frac_period[%0d] got %0d want %0d", i, n, exp_p[i]);
      end
    end
  endtask

  task automatic test_sync_clr();
    do_reset();
    wait_os(n);
    repeat (39) tick();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    tests++;
    if (os_tick !== 1'b0) begin
      fails++;
      $display("FAIL clr_tick got %b want 0", os_tick);
    end
    for (int k = 1; k <= 4; k++) begin
      wait_os(n);
      tests++;
      if (n !== 40) begin
        fails++;
        $display("FAIL clr_period[%0d] got %0d want 40", k, n);
      end
      tests++;
      if (bit_tick !== (k == 4)) begin
        fails++;
        $display("FAIL clr_bit[%0d] got %b want %b", k, bit_tick, k == 4);
      end
    end
  endtask

  task automatic test_enable();
    int seen;
    do_reset();
    wait_os(n);
    wait_os(n);
    repeat (10) tick();
    en   = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (os_tick || bit_tick) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL en_idle_ticks got %0d want 0", seen);
    end
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_os(n);
      tests++;
      if (n !== 40) begin
        fails++;
        $display("FAIL en_period[%0d] got %0d want 40", k, n);
      end
      tests++;
      if (bit_tick !== (k == 4)) begin
        fails++;
        $display("FAIL en_bit[%0d] got %b want %b", k, bit_tick, k == 4);
      end
    end
    en = 1'b0;
    load(6, 0);
    en = 1'b1;
    wait_os(n);
    tests++;
    if (n !== 6) begin
      fails++;
      $display("FAIL en_idle_load got %0d want 6", n);
    end
  endtask

  task automatic test_reset_mid();
    load(0, 0);
    repeat (3) tick();
    tests++;
    if (div_err !== 1'b1) begin
      fails++;
      $display("FAIL mid_err_pre got %b want 1", div_err);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if ({os_tick, bit_tick, div_err} !== 3'b000) begin
      fails++;
      $display("FAIL mid_reset_out got %b want 000",
               {os_tick, bit_tick, div_err});
    end
    rst_n = 1'b1;
    wait_os(n);
    tests++;
    if (n !== 40) begin
      fails++;
      $display("FAIL mid_reset_period got %0d want 40", n);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_load();
    test_div_err();
    test_frac();
    test_sync_clr();
    test_enable();
    test_reset_mid();
    tests++;
    if (stray !== 0) begin
      fails++;
      $display("FAIL bit_without_os got %0d want 0", stray);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
